packet_rr_arbiter: RTL and testbench

PACKET_RR_ARBITER -- requirements
Module: packet_rr_arbiter

---
 rtl/packet_rr_arbiter_pkg.sv | 11 +
 rtl/packet_rr_arbiter_rr_priority_pick.sv | 35 +++
 rtl/packet_rr_arbiter.sv | 74 +++++++
 tb/tb_packet_rr_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/packet_rr_arbiter_pkg.sv
// Shared types and defaults for the packet round-robin arbiter.
package packet_rr_arbiter_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/packet_rr_arbiter_rr_priority_pick.sv
// Combinational rotating-priority search: the first set req bit at or after ptr wins.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  int unsigned   cand;
  logic [PW-1:0] cand_idx;

  always_comb begin
    onehot_o = '0;
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      // Explicit modulo-N wrap so non-power-of-two N never indexes past N-1.
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = PW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o            = 1'b1;
        idx_o              = cand_idx;
        onehot_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Packet-locked round-robin arbiter: a grant is held from arbitration until the winner's fin.
module packet_rr_arbiter
  import packet_rr_arbiter_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] fin,
  input  logic         ready,
  output logic [N-1:0] grant,
  output state_t       dbg_state_o
);

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  pick_onehot;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  rr_priority_pick #(.N(N), .PW(PW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (ready && pick_valid) begin
          state_d = BUSY;
          grant_d = pick_onehot;
          ptr_d   = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      BUSY: begin
        // Only the owner's fin ends the packet; other fin bits are masked off.
        if (|(fin & grant_q)) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed bench for packet_rr_arbiter with hand-computed grant sequences.
module tb_packet_rr_arbiter;
  import packet_rr_arbiter_pkg::*;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] fin;
  logic       ready;
  logic [3:0] grant;
  state_t     dbg_state;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  packet_rr_arbiter #(.N(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .fin         (fin),
    .ready       (ready),
    .grant       (grant),
    .dbg_state_o (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt = check_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] exp);
    chk(tag, 32'(grant), 32'(exp));
    chk({tag, "_onehot0"}, 32'($onehot0(grant)), 32'd1);
  endtask

  logic [3:0] exp_v;

  initial begin
    reset = 1'b1; req = '0; fin = '0; ready = 1'b0;
    tick();
    tick();
    chk_grant("reset_grant", 4'b0000);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));

    // Requests present while reset is still high must not produce a grant.
    req = 4'b1111; ready = 1'b1;
    tick();
    chk_grant("reset_override", 4'b0000);
    reset = 1'b0;
    tick();

    // Full rotation: each owner holds for 5 cycles, then fin + drop req.
    exp_v = 4'b0001;
    for (int w = 0; w < 4; w++) begin
      chk_grant("rr_grant", exp_v);
      chk("rr_state_busy", 32'(dbg_state), 32'(BUSY));
      for (int c = 0; c < 4; c++) begin
        ready = c[0];
        tick();
        chk_grant("rr_hold", exp_v);
      end
      ready = 1'b1;
      fin = exp_v; req = req & ~exp_v;
      tick();
      fin = '0;
      chk_grant("rr_idle_gap", 4'b0000);
      if (w < 3) tick();
      exp_v = exp_v << 1;
    end

    // Wrap-around with ptr back at 0.
    req = 4'b1001;
    tick();
    chk_grant("wrap_first", 4'b0001);
    fin = 4'b0001; req = 4'b1000;
    tick();
    fin = '0;
    chk_grant("wrap_gap", 4'b0000);
    tick();
    chk_grant("wrap_second", 4'b1000);
    fin = 4'b1000; req = '0;
    tick();
    fin = '0;
    chk_grant("wrap_end", 4'b0000);

    // ready low blocks arbitration; fin in IDLE is ignored.
    ready = 1'b0; req = 4'b0100; fin = 4'b1111;
    tick();
    fin = '0;
    chk_grant("notready_0", 4'b0000);
    tick();
    chk_grant("notready_1", 4'b0000);
    ready = 1'b1;
    #1;
    chk_grant("no_comb_path", 4'b0000);
    tick();
    chk_grant("ready_grant", 4'b0100);
    fin = 4'b0100; req = '0;
    tick();
    fin = '0;
    chk_grant("ready_end", 4'b0000);

    // ptr=3: 3 wins, then finishes while still requesting and drops to lowest priority.
    req = 4'b1010;
    tick();
    chk_grant("ptr3_pick", 4'b1000);
    fin = 4'b1000;
    tick();
    fin = '0;
    chk_grant("fin_with_req", 4'b0000);
    tick();
    chk_grant("requeue_pick", 4'b0010);

    // Packet lock: foreign fin and dropped req do not release the owner.
    fin = 4'b0100; req = 4'b1000; ready = 1'b0;
    tick();
    fin = '0;
    chk_grant("lock_foreign_fin", 4'b0010);
    ready = 1'b1;
    tick();
    chk_grant("lock_req_drop", 4'b0010);
    tick();
    chk_grant("lock_hold", 4'b0010);
    fin = 4'b0010;
    tick();
    fin = '0;
    chk_grant("lock_release", 4'b0000);
    tick();
    chk_grant("lock_next", 4'b1000);
    fin = 4'b1000; req = '0;
    tick();
    fin = '0;
    chk_grant("lock_next_end", 4'b0000);

    // Reset mid-packet aborts the grant and clears ptr.
    req = 4'b0100;
    tick();
    chk_grant("abort_grant", 4'b0100);
    reset = 1'b1;
    tick();
    chk_grant("abort_reset", 4'b0000);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0; req = 4'b0110;
    tick();
    chk_grant("after_reset_0110", 4'b0010);
    fin = 4'b0010; req = '0;
    tick();
    fin = '0;
    chk_grant("after_reset_end", 4'b0000);

    // Discriminating ptr reset: ptr=3 before reset would otherwise pick bit 3.
    req = 4'b0100;
    tick();
    chk_grant("ptr_setup", 4'b0100);
    reset = 1'b1; req = '0;
    tick();
    chk_grant("ptr_reset", 4'b0000);
    reset = 1'b0; req = 4'b1100;
    tick();
    chk_grant("ptr_cleared", 4'b0100);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
